// File: rtl/tcm_dport_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tcm_dport_arbiter_pkg
// Shared definitions for the TCM data-port arbiter and its source FIFO.
//   owner_e        : which requester currently holds / is granted the port
//   SRC_CPU/SRC_SPI: value stored in the source FIFO for each accepted request
//   TAG_W_DEFAULT  : default CPU tag width
//   ptr_width()    : pointer width for a FIFO of a given depth (at least 1 bit)
// -----------------------------------------------------------------------------
package tcm_dport_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_SPI  = 2'd2
  } owner_e;

  localparam logic SRC_CPU = 1'b0;
  localparam logic SRC_SPI = 1'b1;

  localparam int TAG_W_DEFAULT = 11;

  // A depth-1 FIFO still needs a 1-bit pointer so the vectors stay legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tcm_dport_arbiter_src_fifo.sv
// -----------------------------------------------------------------------------
// tcm_src_fifo
// 1-bit wide, in-order FIFO remembering which requester issued each accepted
// TCM request, so responses can be routed back in order.
// Ports:
//   clk_i, rstn_i   : clock, asynchronous active-low reset
//   push_i          : store push_src_i (ignored when full)
//   push_src_i      : source bit to store
//   pop_i           : drop the head entry (ignored when empty)
//   head_o          : source bit of the oldest entry (valid when !empty_o)
//   count_o         : number of stored entries
//   full_o, empty_o : occupancy flags
// -----------------------------------------------------------------------------
module tcm_src_fifo
  import tcm_dport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  logic                       push_src_i,
  input  logic                       pop_i,
  output logic                       head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_ptr_inc;
  logic [PTR_W-1:0] w_rd_ptr_inc;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  // Explicit wrap keeps the pointers correct for DEPTH == 1 as well.
  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_src_i;
        r_wr_ptr        <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tcm_dport_arbiter.sv
// -----------------------------------------------------------------------------
// tcm_dport_arbiter
// Shares the single TCM data port between the CPU data interface and the SPI
// debug/loader master. SPI has priority, but after SPI_BURST_MAX consecutive
// SPI accepts with a CPU request waiting, the CPU is granted once. A grant is
// held until accepted, and responses are routed back to their originator via
// an in-order source FIFO (zero-latency routing).
// Ports:
//   clk_i, rstn_i       : clock, asynchronous active-low reset
//   cpu_*_i / cpu_*_o   : CPU request (addr, wdata, rd, byte strobes,
//                         side-band, tag) and accept/ack/error/resp tag
//   spi_*_i / spi_*_o   : SPI request (addr, wdata, rd, strobes), accept/ack
//   data_rd_o           : TCM read data, broadcast to both requesters
//   mem_*_o / mem_*_i   : TCM request port and response
//   busy_o              : at least one request outstanding
//   protocol_err_o      : sticky, TCM acked with nothing outstanding
// -----------------------------------------------------------------------------
module tcm_dport_arbiter
  import tcm_dport_arbiter_pkg::*;
#(
  parameter int OUTSTANDING   = 2,
  parameter int SPI_BURST_MAX = 4,
  parameter int TAG_W         = TAG_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  // CPU request side
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_data_wr_i,
  input  logic             cpu_rd_i,
  input  logic [3:0]       cpu_wr_i,
  input  logic             cpu_cacheable_i,
  input  logic             cpu_invalidate_i,
  input  logic             cpu_writeback_i,
  input  logic             cpu_flush_i,
  input  logic [TAG_W-1:0] cpu_req_tag_i,
  output logic             cpu_accept_o,
  output logic             cpu_ack_o,
  output logic             cpu_error_o,
  output logic [TAG_W-1:0] cpu_resp_tag_o,
  // SPI request side
  input  logic [31:0]      spi_addr_i,
  input  logic [31:0]      spi_data_wr_i,
  input  logic             spi_rd_i,
  input  logic [3:0]       spi_wr_i,
  output logic             spi_accept_o,
  output logic             spi_ack_o,
  // Shared read data
  output logic [31:0]      data_rd_o,
  // TCM port
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_wr_o,
  output logic             mem_rd_o,
  output logic [3:0]       mem_wr_o,
  output logic             mem_cacheable_o,
  output logic             mem_invalidate_o,
  output logic             mem_writeback_o,
  output logic             mem_flush_o,
  output logic [TAG_W-1:0] mem_req_tag_o,
  input  logic             mem_accept_i,
  input  logic             mem_ack_i,
  input  logic             mem_error_i,
  input  logic [31:0]      mem_data_rd_i,
  input  logic [TAG_W-1:0] mem_resp_tag_i,
  // Status
  output logic             busy_o,
  output logic             protocol_err_o
);

  localparam int CNT_W    = $clog2(OUTSTANDING + 1);
  localparam int STREAK_W = $clog2(SPI_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(SPI_BURST_MAX);

  owner_e              r_hold;
  owner_e              w_hold_next;
  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_next;
  logic                r_proto_err;

  owner_e              w_grant;
  logic                w_cpu_req;
  logic                w_spi_req;
  logic                w_push;
  logic                w_push_src;
  logic                w_fifo_head;
  logic [CNT_W-1:0]    w_fifo_count;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_ack_valid;

  assign w_cpu_req = cpu_rd_i | (|cpu_wr_i) | cpu_invalidate_i | cpu_writeback_i | cpu_flush_i;
  assign w_spi_req = spi_rd_i | (|spi_wr_i);

  // ---------------------------------------------------------------------------
  // Grant selection. A full FIFO blocks every grant, even in a cycle where an
  // ack frees an entry; this keeps the accept path independent of mem_ack_i.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_grant = OWN_NONE;
    if (w_fifo_full) begin
      w_grant = OWN_NONE;
    end else if ((r_hold == OWN_CPU) && w_cpu_req) begin
      w_grant = OWN_CPU;
    end else if ((r_hold == OWN_SPI) && w_spi_req) begin
      w_grant = OWN_SPI;
    end else if (w_cpu_req && w_spi_req) begin
      w_grant = (r_streak == STREAK_MAX) ? OWN_CPU : OWN_SPI;
    end else if (w_cpu_req) begin
      w_grant = OWN_CPU;
    end else if (w_spi_req) begin
      w_grant = OWN_SPI;
    end
  end

  assign cpu_accept_o = (w_grant == OWN_CPU) & mem_accept_i;
  assign spi_accept_o = (w_grant == OWN_SPI) & mem_accept_i;

  // ---------------------------------------------------------------------------
  // Next-state logic for the hold owner and the SPI streak counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_hold_next   = OWN_NONE;
    w_streak_next = r_streak;

    if (w_grant != OWN_NONE) begin
      w_hold_next = mem_accept_i ? OWN_NONE : w_grant;
    end else if (w_fifo_full) begin
      // Nothing could be granted this cycle; keep any owner that is waiting.
      w_hold_next = r_hold;
    end
    // An owner that dropped its request falls out of the first branch because
    // it is no longer granted, which releases the hold silently.

    if (!w_cpu_req || cpu_accept_o) begin
      w_streak_next = '0;
    end else if (spi_accept_o && (r_streak < STREAK_MAX)) begin
      w_streak_next = r_streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hold      <= OWN_NONE;
      r_streak    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_hold      <= w_hold_next;
      r_streak    <= w_streak_next;
      r_proto_err <= r_proto_err | (mem_ack_i & w_fifo_empty);
    end
  end

  // ---------------------------------------------------------------------------
  // TCM request mux. SPI carries no side-band or tag.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr_o       = '0;
    mem_data_wr_o    = '0;
    mem_rd_o         = 1'b0;
    mem_wr_o         = '0;
    mem_cacheable_o  = 1'b0;
    mem_invalidate_o = 1'b0;
    mem_writeback_o  = 1'b0;
    mem_flush_o      = 1'b0;
    mem_req_tag_o    = '0;
    case (w_grant)
      OWN_CPU: begin
        mem_addr_o       = cpu_addr_i;
        mem_data_wr_o    = cpu_data_wr_i;
        mem_rd_o         = cpu_rd_i;
        mem_wr_o         = cpu_wr_i;
        mem_cacheable_o  = cpu_cacheable_i;
        mem_invalidate_o = cpu_invalidate_i;
        mem_writeback_o  = cpu_writeback_i;
        mem_flush_o      = cpu_flush_i;
        mem_req_tag_o    = cpu_req_tag_i;
      end
      OWN_SPI: begin
        mem_addr_o    = spi_addr_i;
        mem_data_wr_o = spi_data_wr_i;
        mem_rd_o      = spi_rd_i;
        mem_wr_o      = spi_wr_i;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Source FIFO and response routing.
  // ---------------------------------------------------------------------------
  assign w_push     = cpu_accept_o | spi_accept_o;
  assign w_push_src = spi_accept_o ? SRC_SPI : SRC_CPU;

  tcm_src_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_src_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .push_i     (w_push),
    .push_src_i (w_push_src),
    .pop_i      (mem_ack_i),
    .head_o     (w_fifo_head),
    .count_o    (w_fifo_count),
    .full_o     (w_fifo_full),
    .empty_o    (w_fifo_empty)
  );

  // An ack with nothing outstanding is routed nowhere.
  assign w_ack_valid    = mem_ack_i & ~w_fifo_empty;
  assign cpu_ack_o      = w_ack_valid & (w_fifo_head == SRC_CPU);
  assign spi_ack_o      = w_ack_valid & (w_fifo_head == SRC_SPI);
  assign cpu_error_o    = cpu_ack_o & mem_error_i;
  assign cpu_resp_tag_o = cpu_ack_o ? mem_resp_tag_i : '0;
  assign data_rd_o      = mem_data_rd_i;

  assign busy_o         = (w_fifo_count != '0);
  assign protocol_err_o = r_proto_err;

endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tcm_dport_arbiter
// Directed bench for tcm_dport_arbiter. Expected responses are pushed to a
// scoreboard queue when a request is expected to be accepted, then popped and
// compared when the bench's TCM model acks. Inputs change 1 time unit after
// the rising edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_tcm_dport_arbiter;
  import tcm_dport_arbiter_pkg::*;

  localparam int TAG_W = 11;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic [31:0]      cpu_addr_i, cpu_data_wr_i;
  logic             cpu_rd_i;
  logic [3:0]       cpu_wr_i;
  logic             cpu_cacheable_i, cpu_invalidate_i, cpu_writeback_i, cpu_flush_i;
  logic [TAG_W-1:0] cpu_req_tag_i;
  logic             cpu_accept_o, cpu_ack_o, cpu_error_o;
  logic [TAG_W-1:0] cpu_resp_tag_o;
  logic [31:0]      spi_addr_i, spi_data_wr_i;
  logic             spi_rd_i;
  logic [3:0]       spi_wr_i;
  logic             spi_accept_o, spi_ack_o;
  logic [31:0]      data_rd_o;
  logic [31:0]      mem_addr_o, mem_data_wr_o;
  logic             mem_rd_o;
  logic [3:0]       mem_wr_o;
  logic             mem_cacheable_o, mem_invalidate_o, mem_writeback_o, mem_flush_o;
  logic [TAG_W-1:0] mem_req_tag_o;
  logic             mem_accept_i, mem_ack_i, mem_error_i;
  logic [31:0]      mem_data_rd_i;
  logic [TAG_W-1:0] mem_resp_tag_i;
  logic             busy_o, protocol_err_o;

  always #5 clk_i = ~clk_i;

  tcm_dport_arbiter #(
    .OUTSTANDING   (2),
    .SPI_BURST_MAX (4),
    .TAG_W         (TAG_W)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .cpu_addr_i       (cpu_addr_i),
    .cpu_data_wr_i    (cpu_data_wr_i),
    .cpu_rd_i         (cpu_rd_i),
    .cpu_wr_i         (cpu_wr_i),
    .cpu_cacheable_i  (cpu_cacheable_i),
    .cpu_invalidate_i (cpu_invalidate_i),
    .cpu_writeback_i  (cpu_writeback_i),
    .cpu_flush_i      (cpu_flush_i),
    .cpu_req_tag_i    (cpu_req_tag_i),
    .cpu_accept_o     (cpu_accept_o),
    .cpu_ack_o        (cpu_ack_o),
    .cpu_error_o      (cpu_error_o),
    .cpu_resp_tag_o   (cpu_resp_tag_o),
    .spi_addr_i       (spi_addr_i),
    .spi_data_wr_i    (spi_data_wr_i),
    .spi_rd_i         (spi_rd_i),
    .spi_wr_i         (spi_wr_i),
    .spi_accept_o     (spi_accept_o),
    .spi_ack_o        (spi_ack_o),
    .data_rd_o        (data_rd_o),
    .mem_addr_o       (mem_addr_o),
    .mem_data_wr_o    (mem_data_wr_o),
    .mem_rd_o         (mem_rd_o),
    .mem_wr_o         (mem_wr_o),
    .mem_cacheable_o  (mem_cacheable_o),
    .mem_invalidate_o (mem_invalidate_o),
    .mem_writeback_o  (mem_writeback_o),
    .mem_flush_o      (mem_flush_o),
    .mem_req_tag_o    (mem_req_tag_o),
    .mem_accept_i     (mem_accept_i),
    .mem_ack_i        (mem_ack_i),
    .mem_error_i      (mem_error_i),
    .mem_data_rd_i    (mem_data_rd_i),
    .mem_resp_tag_i   (mem_resp_tag_i),
    .busy_o           (busy_o),
    .protocol_err_o   (protocol_err_o)
  );

  typedef struct {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  // TCM model: answer the oldest expected request.
  task automatic ack_drive(output exp_t e);
    e = sb.pop_front();
    mem_ack_i      = 1'b1;
    mem_resp_tag_i = e.tag;
    mem_data_rd_i  = e.data;
    mem_error_i    = e.err;
  endtask

  task automatic ack_clear();
    mem_ack_i      = 1'b0;
    mem_resp_tag_i = '0;
    mem_data_rd_i  = '0;
    mem_error_i    = 1'b0;
  endtask

  task automatic ack_check(input string name, input exp_t e);
    logic is_cpu;
    is_cpu = (e.src == SRC_CPU);
    chk({name, "_cpu_ack"}, cpu_ack_o, is_cpu);
    chk({name, "_spi_ack"}, spi_ack_o, !is_cpu);
    chk({name, "_cpu_err"}, cpu_error_o, is_cpu & e.err);
    chk({name, "_resp_tag"}, cpu_resp_tag_o, is_cpu ? e.tag : '0);
    chk({name, "_data"}, data_rd_o, e.data);
    $display("ack %s: src=%s tag=0x%0h data=0x%08h err=%0b", name,
             is_cpu ? "cpu" : "spi", e.tag, e.data, e.err);
  endtask

  task automatic push_exp(input logic src, input logic [TAG_W-1:0] tag,
                          input logic [31:0] data, input logic err);
    exp_t e;
    e.src = src; e.tag = tag; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  initial begin
    exp_t             e;
    logic             have;
    logic [TAG_W-1:0] cpu_tag;
    logic             grant_spi [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                         1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rstn_i = 1'b0;
    cpu_addr_i = '0; cpu_data_wr_i = '0; cpu_rd_i = 1'b0; cpu_wr_i = '0;
    cpu_cacheable_i = 1'b0; cpu_invalidate_i = 1'b0; cpu_writeback_i = 1'b0;
    cpu_flush_i = 1'b0; cpu_req_tag_i = '0;
    spi_addr_i = '0; spi_data_wr_i = '0; spi_rd_i = 1'b0; spi_wr_i = '0;
    mem_accept_i = 1'b0;
    ack_clear();

    // ---------------- reset state ----------------
    settle();
    chk("rst_cpu_accept", cpu_accept_o, 0);
    chk("rst_spi_accept", spi_accept_o, 0);
    chk("rst_acks", {cpu_ack_o, spi_ack_o, cpu_error_o}, 0);
    chk("rst_mem_req", {mem_rd_o, mem_wr_o, mem_cacheable_o, mem_flush_o}, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_proto_err", protocol_err_o, 0);
    tick();
    rstn_i = 1'b1;
    settle();
    chk("idle_mem_addr", mem_addr_o, 0);
    chk("idle_status", {busy_o, protocol_err_o, cpu_resp_tag_o}, 0);
    tick();

    // ---------------- CPU-only read ----------------
    cpu_addr_i = 32'h8000_0010; cpu_rd_i = 1'b1; cpu_req_tag_i = 11'h05;
    mem_accept_i = 1'b1;
    settle();
    chk("t1_cpu_accept", cpu_accept_o, 1);
    chk("t1_spi_accept", spi_accept_o, 0);
    chk("t1_mem_addr", mem_addr_o, 32'h8000_0010);
    chk("t1_mem_rd", mem_rd_o, 1);
    chk("t1_mem_tag", mem_req_tag_o, 11'h05);
    push_exp(SRC_CPU, 11'h05, 32'hDEAD_BEEF, 1'b0);
    tick();
    cpu_rd_i = 1'b0;
    ack_drive(e);
    settle();
    ack_check("t1", e);
    chk("t1_busy", busy_o, 1);
    tick();
    ack_clear();
    settle();
    chk("t1_busy_after", busy_o, 0);
    tick();

    // ---------------- both requesting: starvation limit ----------------
    cpu_tag = 11'h10;
    cpu_addr_i = 32'h8000_0100; cpu_rd_i = 1'b1; cpu_cacheable_i = 1'b1;
    spi_addr_i = 32'h0000_1000; spi_rd_i = 1'b1;
    mem_accept_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      have = (sb.size() != 0);
      if (have) ack_drive(e);
      else ack_clear();
      cpu_req_tag_i = cpu_tag;
      settle();
      if (have) ack_check($sformatf("t2_%0d", i), e);
      chk($sformatf("t2_spi_grant%0d", i), spi_accept_o, grant_spi[i]);
      chk($sformatf("t2_cpu_grant%0d", i), cpu_accept_o, !grant_spi[i]);
      chk($sformatf("t2_mem_tag%0d", i), mem_req_tag_o, grant_spi[i] ? '0 : cpu_tag);
      chk($sformatf("t2_mem_cache%0d", i), mem_cacheable_o, !grant_spi[i]);
      push_exp(grant_spi[i] ? SRC_SPI : SRC_CPU, grant_spi[i] ? '0 : cpu_tag,
               32'hA000_0000 + 32'(i), (i == 9) || grant_spi[i]);
      tick();
      if (!grant_spi[i]) cpu_tag = cpu_tag + 11'd1;
    end
    cpu_rd_i = 1'b0; spi_rd_i = 1'b0; cpu_cacheable_i = 1'b0;
    ack_drive(e);
    settle();
    ack_check("t2_last", e);
    chk("t2_no_accept", {cpu_accept_o, spi_accept_o}, 0);
    tick();
    ack_clear();

    // ---------------- SPI write held, then FIFO full ----------------
    spi_wr_i = 4'h3; spi_addr_i = 32'h0000_2000; spi_data_wr_i = 32'h1234_5678;
    mem_accept_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        cpu_rd_i = 1'b1; cpu_addr_i = 32'h8000_0200; cpu_req_tag_i = 11'h07;
      end
      if (c == 3) mem_accept_i = 1'b1;
      settle();
      chk($sformatf("t3_addr%0d", c), mem_addr_o, 32'h0000_2000);
      chk($sformatf("t3_wr%0d", c), {mem_wr_o, mem_rd_o}, {4'h3, 1'b0});
      chk($sformatf("t3_wdata%0d", c), mem_data_wr_o, 32'h1234_5678);
      chk($sformatf("t3_spi_acc%0d", c), spi_accept_o, (c == 3));
      chk($sformatf("t3_cpu_acc%0d", c), cpu_accept_o, 0);
      if (c == 3) push_exp(SRC_SPI, '0, 32'h0, 1'b1);
      tick();
    end
    spi_wr_i = '0;
    settle();
    chk("t3_cpu_acc", cpu_accept_o, 1);
    chk("t3_cpu_addr", mem_addr_o, 32'h8000_0200);
    push_exp(SRC_CPU, 11'h07, 32'h5555_0007, 1'b1);
    tick();
    cpu_req_tag_i = 11'h08;
    settle();
    chk("t3_full_block", {cpu_accept_o, mem_rd_o}, 0);
    chk("t3_full_busy", busy_o, 1);
    tick();
    ack_drive(e);
    settle();
    ack_check("t3_a", e);
    chk("t3_full_pop_block", {cpu_accept_o, mem_rd_o}, 0);
    tick();
    ack_drive(e);
    settle();
    ack_check("t3_b", e);
    chk("t3_resume", cpu_accept_o, 1);
    push_exp(SRC_CPU, 11'h08, 32'h5555_0008, 1'b0);
    tick();
    cpu_rd_i = 1'b0;
    ack_drive(e);
    settle();
    ack_check("t3_c", e);
    tick();
    ack_clear();

    // ---------------- CPU holds grant against SPI ----------------
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h8000_0300; cpu_req_tag_i = 11'h09;
    mem_accept_i = 1'b0;
    settle();
    chk("t4_cpu_first", mem_addr_o, 32'h8000_0300);
    tick();
    spi_rd_i = 1'b1; spi_addr_i = 32'h0000_3000;
    settle();
    chk("t4_cpu_held", mem_addr_o, 32'h8000_0300);
    chk("t4_no_spi", spi_accept_o, 0);
    tick();
    mem_accept_i = 1'b1;
    settle();
    chk("t4_cpu_acc", {cpu_accept_o, spi_accept_o}, 2'b10);
    push_exp(SRC_CPU, 11'h09, 32'h0000_0C09, 1'b0);
    tick();
    cpu_rd_i = 1'b0;
    ack_drive(e);
    settle();
    ack_check("t4_a", e);
    chk("t4_spi_acc", {cpu_accept_o, spi_accept_o}, 2'b01);
    push_exp(SRC_SPI, '0, 32'h0000_5A5A, 1'b0);
    tick();
    spi_rd_i = 1'b0;
    ack_drive(e);
    settle();
    ack_check("t4_b", e);
    tick();
    ack_clear();

    // ---------------- spurious ack, then reset mid-transfer ----------------
    mem_ack_i = 1'b1; mem_resp_tag_i = 11'h03; mem_error_i = 1'b1;
    settle();
    chk("t5_spur_acks", {cpu_ack_o, spi_ack_o, cpu_error_o}, 0);
    chk("t5_spur_tag", cpu_resp_tag_o, 0);
    tick();
    ack_clear();
    settle();
    chk("t5_proto_set", protocol_err_o, 1);
    tick();
    tick();
    settle();
    chk("t5_proto_sticky", protocol_err_o, 1);
    tick();
    spi_rd_i = 1'b1; spi_addr_i = 32'h0000_4000; mem_accept_i = 1'b1;
    settle();
    chk("t5_spi_acc", spi_accept_o, 1);
    tick();
    spi_rd_i = 1'b0; cpu_rd_i = 1'b1; cpu_addr_i = 32'h8000_0400; mem_accept_i = 1'b0;
    settle();
    chk("t5_busy", busy_o, 1);
    chk("t5_cpu_granted", mem_addr_o, 32'h8000_0400);
    tick();
    #2;
    rstn_i = 1'b0;
    #1;
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_proto", protocol_err_o, 0);
    sb.delete();
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    spi_rd_i = 1'b1; spi_addr_i = 32'h0000_4400;
    settle();
    chk("t5_hold_cleared", mem_addr_o, 32'h0000_4400);
    chk("t5_post_rst_proto", protocol_err_o, 0);
    tick();
    cpu_rd_i = 1'b0; spi_rd_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
